// File: rtl/fifo_sync_flags_if.sv
// Producer/consumer-facing bundle of the flagged synchronous FIFO.
// The FIFO drives the status side through the slave modport; the user side takes the master modport.
interface fifo_sync_flags_if #(
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_WIDTH = 32
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                  cs;
    logic                  wr_en;
    logic                  rd_en;
    logic                  flush;
    logic                  clr_err;
    logic [FIFO_WIDTH-1:0] data_in;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  empty;
    logic                  full;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output cs, wr_en, rd_en, flush, clr_err, data_in,
        input  data_out, empty, full, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  cs, wr_en, rd_en, flush, clr_err, data_in,
        output data_out, empty, full, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_flags.sv
// Single-clock show-ahead FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and a synchronous flush.
module fifo_sync_flags #(
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_WIDTH = 32,
    parameter int AFULL_TH   = 14,
    parameter int AEMPTY_TH  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    fifo_sync_flags_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    localparam logic [PW-1:0] PTR_ZERO    = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE     = PW'(1);
    localparam logic [PW-1:0] AFULL_TH_C  = PW'(AFULL_TH);
    localparam logic [PW-1:0] AEMPTY_TH_C = PW'(AEMPTY_TH);

    logic [FIFO_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_r;
    logic [PW-1:0]         rd_ptr_r;
    logic                  overflow_r;
    logic                  underflow_r;

    logic                  empty_s;
    logic                  full_s;
    logic [PW-1:0]         count_s;
    logic                  wr_acc_s;
    logic                  rd_acc_s;
    logic                  ovf_set_s;
    logic                  udf_set_s;

    // Status flags come from the registered pointers only, so there is no input-to-output path.
    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
    assign count_s = wr_ptr_r - rd_ptr_r;

    // Acceptance uses this cycle's full/empty, so a same-cycle pop never makes room for a push.
    assign wr_acc_s  = bus.cs & bus.wr_en & ~full_s  & ~bus.flush;
    assign rd_acc_s  = bus.cs & bus.rd_en & ~empty_s & ~bus.flush;
    assign ovf_set_s = bus.cs & bus.wr_en &  full_s  & ~bus.flush;
    assign udf_set_s = bus.cs & bus.rd_en &  empty_s & ~bus.flush;

    assign bus.data_out     = mem_r[rd_ptr_r[AW-1:0]];
    assign bus.empty        = empty_s;
    assign bus.full         = full_s;
    assign bus.count        = count_s;
    assign bus.almost_full  = (count_s >= AFULL_TH_C);
    assign bus.almost_empty = (count_s <= AEMPTY_TH_C);
    assign bus.overflow     = overflow_r;
    assign bus.underflow    = underflow_r;

    // Pointer update; flush overrides any push or pop issued in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
        end else if (bus.flush) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Storage array; cleared by reset so the head word reads back as zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {FIFO_WIDTH{1'b0}};
            end
        end else if (wr_acc_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= bus.data_in;
        end
    end

    // Sticky error flags; a new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end else if (bus.clr_err) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
            if (udf_set_s) begin
                underflow_r <= 1'b1;
            end else if (bus.clr_err) begin
                underflow_r <= 1'b0;
            end else begin
                underflow_r <= underflow_r;
            end
        end
    end
endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed bench for fifo_sync_flags: a reference queue predicts contents and flags,
// and a negedge monitor compares every accepted pop against the scoreboard.
module tb_fifo_sync_flags;
    localparam int DEPTH = 16;
    localparam int WIDTH = 32;

    logic clk;
    logic rst_n;

    fifo_sync_flags_if #(.FIFO_DEPTH(DEPTH), .FIFO_WIDTH(WIDTH)) bus ();

    fifo_sync_flags #(
        .FIFO_DEPTH(DEPTH), .FIFO_WIDTH(WIDTH), .AFULL_TH(14), .AEMPTY_TH(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] exp_q[$];
    bit ovf_m = 1'b0;
    bit udf_m = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: whenever a pop the bench expects to be accepted is on the bus, check the head word.
    always @(negedge clk) begin
        logic [WIDTH-1:0] e;
        if (bus.cs && bus.rd_en && !bus.flush && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rd_data", bus.data_out, e);
        end
    end

    // One clock of stimulus; the reference model is updated with the expected outcome.
    task automatic op(input bit c, input bit w, input bit r, input bit f, input bit ce,
                      input logic [WIDTH-1:0] d);
        bit full_m, empty_m, wacc, racc;
        full_m  = (model_q.size() == DEPTH);
        empty_m = (model_q.size() == 0);
        wacc = c & w & !full_m & !f;
        racc = c & r & !empty_m & !f;
        bus.cs = c; bus.wr_en = w; bus.rd_en = r; bus.flush = f; bus.clr_err = ce; bus.data_in = d;
        if (racc) exp_q.push_back(model_q.pop_front());
        if (wacc) model_q.push_back(d);
        if (f) model_q.delete();
        if (c & w & full_m & !f) ovf_m = 1'b1;
        else if (ce) ovf_m = 1'b0;
        if (c & r & empty_m & !f) udf_m = 1'b1;
        else if (ce) udf_m = 1'b0;
        @(posedge clk);
        #1;
        bus.cs = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.flush = 1'b0; bus.clr_err = 1'b0;
    endtask

    task automatic check_state(input string tag);
        int n;
        n = model_q.size();
        chk({tag, ".count"}, 32'(bus.count), 32'(n));
        chk({tag, ".empty"}, 32'(bus.empty), 32'(n == 0));
        chk({tag, ".full"}, 32'(bus.full), 32'(n == DEPTH));
        chk({tag, ".afull"}, 32'(bus.almost_full), 32'(n >= 14));
        chk({tag, ".aempty"}, 32'(bus.almost_empty), 32'(n <= 2));
        chk({tag, ".ovf"}, 32'(bus.overflow), 32'(ovf_m));
        chk({tag, ".udf"}, 32'(bus.underflow), 32'(udf_m));
        if (n > 0) chk({tag, ".head"}, bus.data_out, model_q[0]);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".count"}, 32'(bus.count), 32'd0);
        chk({tag, ".empty"}, 32'(bus.empty), 32'd1);
        chk({tag, ".full"}, 32'(bus.full), 32'd0);
        chk({tag, ".afull"}, 32'(bus.almost_full), 32'd0);
        chk({tag, ".aempty"}, 32'(bus.almost_empty), 32'd1);
        chk({tag, ".ovf"}, 32'(bus.overflow), 32'd0);
        chk({tag, ".udf"}, 32'(bus.underflow), 32'd0);
        chk({tag, ".data_out"}, bus.data_out, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        bus.cs = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        bus.flush = 1'b0; bus.clr_err = 1'b0; bus.data_in = '0;
        #12;
        check_reset_values("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill 0x0..0xF: count steps, thresholds, head stays 0x0.
        for (int i = 0; i < 16; i++) begin
            op(1, 1, 0, 0, 0, 32'(i));
            check_state("fill");
            chk("fill.head0", bus.data_out, 32'h0);
        end
        chk("fill.full16", 32'(bus.full), 32'd1);

        // Write while full is rejected and sets overflow.
        op(1, 1, 0, 0, 0, 32'hDEAD);
        check_state("ovf");
        chk("ovf.count16", 32'(bus.count), 32'd16);
        chk("ovf.flag", 32'(bus.overflow), 32'd1);

        // Drain 16 words; the monitor checks 0x0..0xF order.
        for (int i = 0; i < 16; i++) begin
            op(1, 0, 1, 0, 0, 32'h0);
            check_state("drain");
        end
        chk("drain.empty", 32'(bus.empty), 32'd1);

        // Underflow, then clear racing a new underflow, then clear alone.
        op(1, 0, 1, 0, 0, 32'h0);
        check_state("udf");
        chk("udf.flag", 32'(bus.underflow), 32'd1);
        op(1, 0, 1, 0, 1, 32'h0);
        chk("udf.setwins", 32'(bus.underflow), 32'd1);
        op(1, 0, 0, 0, 1, 32'h0);
        check_state("clr");
        chk("clr.udf", 32'(bus.underflow), 32'd0);
        chk("clr.ovf", 32'(bus.overflow), 32'd0);

        // Half full, then 20 cycles of simultaneous push/pop across the pointer wrap.
        for (int i = 0; i < 8; i++) op(1, 1, 0, 0, 0, 32'h100 + 32'(i));
        for (int i = 0; i < 20; i++) begin
            op(1, 1, 1, 0, 0, 32'h200 + 32'(i));
            check_state("wrap");
            chk("wrap.count8", 32'(bus.count), 32'd8);
        end
        for (int i = 0; i < 8; i++) op(1, 0, 1, 0, 0, 32'h0);
        check_state("wrapdrain");

        // Simultaneous at empty: write accepted, read rejected.
        op(1, 1, 1, 0, 0, 32'h300);
        check_state("both0");
        chk("both0.count", 32'(bus.count), 32'd1);
        chk("both0.udf", 32'(bus.underflow), 32'd1);
        chk("both0.head", bus.data_out, 32'h300);
        op(1, 0, 0, 0, 1, 32'h0);
        for (int i = 0; i < 15; i++) op(1, 1, 0, 0, 0, 32'h400 + 32'(i));
        check_state("refill");

        // Simultaneous at full: read accepted, write rejected.
        op(1, 1, 1, 0, 0, 32'h500);
        check_state("both16");
        chk("both16.count", 32'(bus.count), 32'd15);
        chk("both16.ovf", 32'(bus.overflow), 32'd1);
        chk("both16.head", bus.data_out, 32'h400);
        op(1, 0, 0, 0, 1, 32'h0);

        // Flush with 5 stored while also pushing and popping.
        op(1, 0, 0, 1, 0, 32'h0);
        for (int i = 0; i < 5; i++) op(1, 1, 0, 0, 0, 32'h600 + 32'(i));
        op(1, 1, 1, 1, 0, 32'hBB);
        check_state("flush");
        chk("flush.count", 32'(bus.count), 32'd0);
        chk("flush.empty", 32'(bus.empty), 32'd1);
        op(1, 1, 0, 0, 0, 32'hAA);
        check_state("postflush");
        chk("postflush.head", bus.data_out, 32'hAA);

        // Asynchronous reset between edges with 10 stored.
        for (int i = 0; i < 9; i++) op(1, 1, 0, 0, 0, 32'h700 + 32'(i));
        chk("prerst.count", 32'(bus.count), 32'd10);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        model_q.delete();
        ovf_m = 1'b0;
        udf_m = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_state("afterrst");

        // Chip select low: requests ignored, no error flags.
        for (int i = 0; i < 3; i++) op(1, 1, 0, 0, 0, 32'h800 + 32'(i));
        for (int i = 0; i < 6; i++) begin
            op(0, i[0], !i[0], 0, 0, 32'h900 + 32'(i));
            check_state("cs0");
            chk("cs0.count", 32'(bus.count), 32'd3);
        end
        for (int i = 0; i < 3; i++) op(1, 0, 1, 0, 0, 32'h0);
        op(0, 0, 1, 0, 0, 32'h0);
        check_state("cs0empty");
        chk("cs0empty.udf", 32'(bus.underflow), 32'd0);

        chk("scoreboard.drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fifo_sync_flags.md
# fifo_sync_flags

Parametrised synchronous FIFO, the successor to our basic single-clock FIFO. It adds an occupancy count, programmable almost-full and almost-empty thresholds, sticky overflow/underflow error flags with a clear, and a synchronous flush. It sits between a producer and a consumer in the same clock domain. It keeps show-ahead read semantics: the head word is always visible on `data_out`.

## Interface
- `FIFO_DEPTH`, 16: number of entries; must be a power of 2 and ≥ 2.
- `FIFO_WIDTH`, 32: data width in bits.
- `AFULL_TH`, 14: `almost_full` asserts when count ≥ `AFULL_TH`; legal range 1..`FIFO_DEPTH`.
- `AEMPTY_TH`, 2: `almost_empty` asserts when count ≤ `AEMPTY_TH`; legal range 0..`FIFO_DEPTH`-1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cs`  in  1  chip select; gates `wr_en` and `rd_en`.
- `wr_en`  in  1  write request.
- `rd_en`  in  1  read (pop) request.
- `flush`  in  1  synchronous flush; not gated by `cs`.
- `clr_err`  in  1  clears the sticky error flags.
- `data_in`  in  `FIFO_WIDTH`  write data.
- `data_out`  out  `FIFO_WIDTH`  head-of-FIFO word (show-ahead).
- `empty`  out  1  count == 0.
- `full`  out  1  count == `FIFO_DEPTH`.
- `almost_full`  out  1  count ≥ `AFULL_TH`.
- `almost_empty`  out  1  count ≤ `AEMPTY_TH`.
- `count`  out  $clog2(`FIFO_DEPTH`)+1  current occupancy, 0..`FIFO_DEPTH`.
- `overflow`  out  1  sticky: a write was attempted while full.
- `underflow`  out  1  sticky: a read was attempted while empty.

## Operation
- Storage is `FIFO_DEPTH` × `FIFO_WIDTH` words.
- Write and read pointers are $clog2(`FIFO_DEPTH`)+1 bits wide. The low bits index storage; the MSB is the wrap bit.
- Pointers wrap naturally at 2·`FIFO_DEPTH`.
- Flags are derived from the pointers:
  - `empty` when the pointers are equal.
  - `full` when the low bits are equal and the MSBs differ.
  - `count` = wr_ptr − rd_ptr, modulo 2^(ptr width).
- Write accepted = `cs` & `wr_en` & !`full` & !`flush`. On acceptance, `data_in` is stored at wr_ptr and wr_ptr increments.
- Read accepted = `cs` & `rd_en` & !`empty` & !`flush`. On acceptance, rd_ptr increments.
- Acceptance is evaluated on the current-cycle `full`/`empty`:
  - Write while full is rejected even if a read is accepted in the same cycle.
  - Read while empty is rejected even if a write is accepted in the same cycle.
- Simultaneous accepted read and write: both pointers advance and `count` is unchanged.
- `flush`: both pointers return to 0 at the next edge. It has priority over `wr_en`/`rd_en` in that cycle. Storage contents are not cleared.
- `overflow` sets on `cs` & `wr_en` & `full` & !`flush`.
- `underflow` sets on `cs` & `rd_en` & `empty` & !`flush`.
- Both error flags hold until `clr_err`. If a set condition and `clr_err` occur in the same cycle, set wins.
- `flush` does not clear the error flags.
- `data_out` = storage[rd_ptr low bits], combinational from registered state.
  - While `empty`, `data_out` shows the stale/initial entry. The bench must not check it in that state.
- `almost_full`, `almost_empty`, `count`, `empty` and `full` are combinational from the registered pointers only; they have no input-to-output path.

## Timing
- Reset (async assert, sync release):
  - Pointers are 0 and all storage words are 0.
  - `data_out` = 0, `empty` = 1, `full` = 0, `count` = 0.
  - `almost_empty` = 1 (because 0 ≤ `AEMPTY_TH`) and `almost_full` = 0.
  - `overflow` = 0 and `underflow` = 0.
- Reset asserted mid-operation discards all contents and returns every output to its reset value immediately, without waiting for a clock edge.
- Write-to-read latency: a word written at edge N is visible on `data_out` after edge N, provided the FIFO was empty. `empty` deasserts after the same edge N.
- A read accepted at edge N presents the next word on `data_out` after edge N.
- All flags and `count` update once per accepted operation, directly after the edge that performed it.
- Error flags update at the edge following the offending request. `clr_err` takes effect at its edge.

## Test plan
- Reset, then write 16 words 0x0..0xF with `cs`=1.
  - Required: `count` steps 1..16; `almost_full` asserts at count 14; `full` asserts at count 16.
  - Required: `almost_empty` deasserts at count 3; `data_out` = 0x0 throughout.
- From full, assert `wr_en` with `data_in`=0xDEAD.
  - Required: rejected; `count` stays 16; `overflow` = 1 after the edge.
  - Then read 16 words. Required: reads return 0x0..0xF in order, ending with `empty` = 1.
- From empty, assert `rd_en`.
  - Required: `underflow` = 1 and `count` stays 0.
  - Then assert `clr_err` together with `rd_en` while still empty. Required: `underflow` stays 1 (set wins).
  - Then assert `clr_err` alone. Required: `underflow` = 0.
- Fill 8 words, then run simultaneous `wr_en`/`rd_en` for 20 cycles to exercise pointer wrap.
  - Required: `count` = 8 throughout and data remains in FIFO order.
  - Repeat at count 0. Required: write accepted, read rejected, `underflow` set.
  - Repeat at count 16. Required: read accepted, write rejected, `overflow` set.
- With 5 words stored, assert `flush` together with `wr_en` and `rd_en`.
  - Required: next cycle `count` = 0 and `empty` = 1, with no new word stored.
  - Required: a subsequent write of 0xAA appears on `data_out`.
- Mid-burst with 10 words stored, pulse `rst_n` low between clock edges.
  - Required: all outputs reach their reset values immediately, and `data_out` = 0.
- `cs`=0 with `wr_en`/`rd_en` toggling.
  - Required: no pointer, count or error-flag change.
